// File: rtl/chunked_addsub_pkg.sv
// Shared types and op encodings for the sequential chunked adder/subtractor.
package chunked_addsub_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK_WIDTH adder with optional B inversion, shared across all chunk slots.
module chunk_adder
    import chunked_addsub_pkg::*;
#(
    parameter int unsigned CHUNK_WIDTH = 8
) (
    input  logic [CHUNK_WIDTH-1:0] a,
    input  logic [CHUNK_WIDTH-1:0] b,
    input  logic                   cin,
    input  logic                   invert_b,
    output logic [CHUNK_WIDTH-1:0] sum,
    output logic                   cout
);

    logic [CHUNK_WIDTH-1:0] w_b;

    always_comb begin
        w_b         = invert_b ? ~b : b;
        {cout, sum} = {1'b0, a} + {1'b0, w_b} + {{CHUNK_WIDTH{1'b0}}, cin};
    end

endmodule

// File: rtl/chunked_addsub_seq.sv
// Multi-cycle adder/subtractor, one CHUNK_WIDTH slice per clock with a registered carry.
// Optional signed overflow output enabled by CHUNKED_ADDSUB_OVERFLOW_EN.
module chunked_addsub_seq
    import chunked_addsub_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned CHUNK_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             ack,
    output logic [WIDTH-1:0] out,
    output logic             carry_out
`ifdef CHUNKED_ADDSUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int unsigned NUM_CHUNKS = WIDTH / CHUNK_WIDTH;
    localparam int unsigned IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    generate
        if (WIDTH % CHUNK_WIDTH != 0) begin : g_bad_cfg
            $error("WIDTH must be a multiple of CHUNK_WIDTH");
        end
    endgenerate

    state_e                 r_state;
    state_e                 w_state_next;
    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic                   r_op_sub;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_carry;
    logic [WIDTH-1:0]       r_out;
    logic                   r_ack;
    logic                   r_carry_out;

    logic                   w_accept;
    logic                   w_last;
    logic [CHUNK_WIDTH-1:0] w_a_chunk;
    logic [CHUNK_WIDTH-1:0] w_b_chunk;
    logic [CHUNK_WIDTH-1:0] w_sum;
    logic                   w_cout;

    assign w_accept  = (r_state == IDLE) && req;
    assign w_last    = (r_idx == LAST_IDX);
    assign w_a_chunk = r_a[r_idx*CHUNK_WIDTH +: CHUNK_WIDTH];
    assign w_b_chunk = r_b[r_idx*CHUNK_WIDTH +: CHUNK_WIDTH];

    chunk_adder #(
        .CHUNK_WIDTH (CHUNK_WIDTH)
    ) u_chunk_adder (
        .a        (w_a_chunk),
        .b        (w_b_chunk),
        .cin      (r_carry),
        .invert_b (r_op_sub == OP_SUB),
        .sum      (w_sum),
        .cout     (w_cout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (req) w_state_next = RUN;
            RUN:     if (w_last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_op_sub    <= OP_ADD;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_out       <= '0;
            r_ack       <= 1'b0;
            r_carry_out <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            if (w_accept) begin
                r_a      <= a;
                r_b      <= b;
                r_op_sub <= op_sub;
                r_idx    <= '0;
                // Subtract is a + ~b + 1: the +1 rides in as the first carry-in.
                r_carry  <= (op_sub == OP_SUB);
            end else if (r_state == RUN) begin
                r_out[r_idx*CHUNK_WIDTH +: CHUNK_WIDTH] <= w_sum;
                r_carry <= w_cout;
                if (w_last) begin
                    r_idx       <= '0;
                    r_ack       <= 1'b1;
                    r_carry_out <= (r_op_sub == OP_SUB) ? ~w_cout : w_cout;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

`ifdef CHUNKED_ADDSUB_OVERFLOW_EN
    logic r_overflow;
    logic w_overflow;
    logic w_a_msb;
    logic w_b_msb;
    logic w_s_msb;

    always_comb begin
        w_a_msb    = r_a[WIDTH-1];
        w_b_msb    = r_b[WIDTH-1];
        w_s_msb    = w_sum[CHUNK_WIDTH-1];
        w_overflow = (r_op_sub == OP_SUB) ? ((w_a_msb != w_b_msb) && (w_s_msb != w_a_msb))
                                          : ((w_a_msb == w_b_msb) && (w_s_msb != w_a_msb));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if ((r_state == RUN) && w_last && !w_accept) begin
            r_overflow <= w_overflow;
        end
    end

    assign overflow = r_overflow;
`endif

    assign busy      = (r_state == RUN);
    assign ack       = r_ack;
    assign out       = r_out;
    assign carry_out = r_carry_out;

endmodule

// File: tb/tb_chunked_addsub_seq.sv
// Scoreboard bench for chunked_addsub_seq: 32/8, 64/16 and 32/32 instances, directed vectors.
module tb_chunked_addsub_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    logic        req0 = 0, sub0 = 0, busy0, ack0, co0, ov0;
    logic [31:0] a0 = 0, b0 = 0, out0;
    logic        req1 = 0, sub1 = 0, busy1, ack1, co1, ov1;
    logic [63:0] a1 = 0, b1 = 0, out1;
    logic        req2 = 0, sub2 = 0, busy2, ack2, co2, ov2;
    logic [31:0] a2 = 0, b2 = 0, out2;

`ifndef CHUNKED_ADDSUB_OVERFLOW_EN
    assign ov0 = 1'b0;
    assign ov1 = 1'b0;
    assign ov2 = 1'b0;
`endif

    chunked_addsub_seq #(.WIDTH(32), .CHUNK_WIDTH(8)) u_dut0 (
        .clk(clk), .rst(rst), .req(req0), .op_sub(sub0), .a(a0), .b(b0),
        .busy(busy0), .ack(ack0), .out(out0), .carry_out(co0)
`ifdef CHUNKED_ADDSUB_OVERFLOW_EN
        , .overflow(ov0)
`endif
    );

    chunked_addsub_seq #(.WIDTH(64), .CHUNK_WIDTH(16)) u_dut1 (
        .clk(clk), .rst(rst), .req(req1), .op_sub(sub1), .a(a1), .b(b1),
        .busy(busy1), .ack(ack1), .out(out1), .carry_out(co1)
`ifdef CHUNKED_ADDSUB_OVERFLOW_EN
        , .overflow(ov1)
`endif
    );

    chunked_addsub_seq #(.WIDTH(32), .CHUNK_WIDTH(32)) u_dut2 (
        .clk(clk), .rst(rst), .req(req2), .op_sub(sub2), .a(a2), .b(b2),
        .busy(busy2), .ack(ack2), .out(out2), .carry_out(co2)
`ifdef CHUNKED_ADDSUB_OVERFLOW_EN
        , .overflow(ov2)
`endif
    );

    typedef struct {
        logic [63:0] out;
        logic        c;
        logic        ov;
        int          ack_cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic score(input int k, input logic [63:0] o, input logic c, input logic ov);
        exp_t e;
        bit   have;
        have = 0;
        case (k)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1; end
        endcase
        if (!have) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_ack%0d: got ack at cycle %0d, expected none", k, cyc);
        end else begin
            cmp($sformatf("out%0d", k), o, e.out);
            cmp($sformatf("carry%0d", k), 64'(c), 64'(e.c));
`ifdef CHUNKED_ADDSUB_OVERFLOW_EN
            cmp($sformatf("overflow%0d", k), 64'(ov), 64'(e.ov));
`endif
            cmp($sformatf("ack_cycle%0d", k), 64'(cyc), 64'(e.ack_cyc));
        end
    endtask

    always @(negedge clk) if (ack0) score(0, 64'(out0), co0, ov0);
    always @(negedge clk) if (ack1) score(1, out1, co1, ov1);
    always @(negedge clk) if (ack2) score(2, 64'(out2), co2, ov2);

    function automatic logic get_busy(input int k);
        case (k)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    task automatic set_req(input int k, input logic r);
        case (k)
            0:       req0 = r;
            1:       req1 = r;
            default: req2 = r;
        endcase
    endtask

    // Waits (bounded) for the instance to go idle, then presents one request for one cycle.
    task automatic issue(input int k, input logic [63:0] ta, input logic [63:0] tb,
                         input logic s, input logic [63:0] eo, input logic ec,
                         input logic eov, input bit push);
        int   n;
        int   nch;
        exp_t e;
        n = 0;
        while (get_busy(k) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            n_vec++;
            n_err++;
            $display("FAIL idle_timeout%0d: busy still 1 after %0d cycles, expected 0", k, n);
        end
        case (k)
            0:       begin a0 = ta[31:0]; b0 = tb[31:0]; sub0 = s; nch = 4; end
            1:       begin a1 = ta;       b1 = tb;       sub1 = s; nch = 4; end
            default: begin a2 = ta[31:0]; b2 = tb[31:0]; sub2 = s; nch = 1; end
        endcase
        set_req(k, 1'b1);
        if (push) begin
            e.out = eo; e.c = ec; e.ov = eov; e.ack_cyc = cyc + nch + 1;
            case (k)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
        @(posedge clk);
        #1;
        set_req(k, 1'b0);
    endtask

    initial begin
        int   t;
        exp_t e;

        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cmp("rst_busy", 64'(busy0), 64'd0);
        cmp("rst_ack", 64'(ack0), 64'd0);
        cmp("rst_out", 64'(out0), 64'd0);
        cmp("rst_carry", 64'(co0), 64'd0);
`ifdef CHUNKED_ADDSUB_OVERFLOW_EN
        cmp("rst_overflow", 64'(ov0), 64'd0);
`endif
        cmp("rst_out1", out1, 64'd0);
        cmp("rst_busy2", 64'(busy2), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors, default 32/8 instance.
        issue(0, 64'h0000_00FF, 64'h0000_0001, 1'b0, 64'h0000_0100, 1'b0, 1'b0, 1);
        cmp("busy_after_accept", 64'(busy0), 64'd1);
        issue(0, 64'h0000_0000, 64'h0000_0001, 1'b1, 64'hFFFF_FFFF, 1'b1, 1'b0, 1);
        issue(0, 64'h7FFF_FFFF, 64'h0000_0001, 1'b0, 64'h8000_0000, 1'b0, 1'b1, 1);
        issue(0, 64'h8000_0000, 64'h0000_0001, 1'b1, 64'h7FFF_FFFF, 1'b0, 1'b1, 1);
        issue(0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE, 1'b1, 1'b0, 1);
        issue(0, 64'h0000_0005, 64'h0000_0005, 1'b1, 64'h0000_0000, 1'b0, 1'b0, 1);
        issue(0, 64'h1234_5678, 64'h9ABC_DEF0, 1'b1, 64'h7777_7788, 1'b1, 1'b0, 1);
        issue(0, 64'h8000_0000, 64'h8000_0000, 1'b0, 64'h0000_0000, 1'b1, 1'b1, 1);

        // Back-to-back with req held high; operand changes during busy must not leak in.
        while (busy0) begin @(posedge clk); #1; end
        t = cyc;
        a0 = 32'd5; b0 = 32'd3; sub0 = 1'b0; req0 = 1'b1;
        e.out = 64'd8; e.c = 1'b0; e.ov = 1'b0; e.ack_cyc = t + 5; q0.push_back(e);
        @(posedge clk);
        #1;
        a0 = 32'd5; b0 = 32'd3; sub0 = 1'b1;
        e.out = 64'd2; e.c = 1'b0; e.ov = 1'b0; e.ack_cyc = t + 10; q0.push_back(e);
        repeat (5) @(posedge clk);
        #1;
        req0 = 1'b0;
        cmp("busy_second_op", 64'(busy0), 64'd1);

        // Wider and single-chunk configurations.
        issue(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0, 1);
        issue(1, 64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1);
        issue(2, 64'h0000_00FF, 64'h0000_0001, 1'b0, 64'h0000_0100, 1'b0, 1'b0, 1);
        issue(2, 64'h8000_0000, 64'h0000_0001, 1'b1, 64'h7FFF_FFFF, 1'b0, 1'b1, 1);

        // Reset two cycles after acceptance drops the in-flight op.
        issue(0, 64'h1122_3344, 64'h0101_0101, 1'b0, 64'd0, 1'b0, 1'b0, 0);
        @(posedge clk);
        #1;
        cmp("partial_chunk0", 64'(out0[7:0]), 64'h45);
        rst = 1'b0;
        #1;
        cmp("midrst_busy", 64'(busy0), 64'd0);
        cmp("midrst_out", 64'(out0), 64'd0);
        cmp("midrst_ack", 64'(ack0), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        cmp("post_rst_idle", 64'(busy0), 64'd0);
        issue(0, 64'h1122_3344, 64'h0101_0101, 1'b0, 64'h1223_3445, 1'b0, 1'b0, 1);

        repeat (12) @(posedge clk);
        #1;
        cmp("q0_drained", 64'(q0.size()), 64'd0);
        cmp("q1_drained", 64'(q1.size()), 64'd0);
        cmp("q2_drained", 64'(q2.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/chunked_addsub_seq.md
# chunked_addsub_seq

Parametrised, multi-cycle integer adder/subtractor that processes its operands one CHUNK_WIDTH slice per clock. A registered carry/borrow links consecutive slices. It is the sequential, width-generalised successor of the integer unit's combinational chunked subtractor. It trades latency for a short critical path: one chunk adder plus one mux. It sits in the int datapath behind a req/ack handshake and reports carry/borrow and, optionally, signed overflow.

## Interface
- WIDTH, 32, operand/result width.
- CHUNK_WIDTH, 8, bits processed per cycle.
  - WIDTH % CHUNK_WIDTH must be 0; otherwise elaboration fails.
  - NUM_CHUNKS = WIDTH/CHUNK_WIDTH.
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  1  start request; sampled only when busy=0.
- op_sub  input  1  0 = a+b, 1 = a-b; latched with operands.
- a  input  WIDTH  operand A, latched on acceptance.
- b  input  WIDTH  operand B, latched on acceptance.
- busy  output  1  operation in progress.
- ack  output  1  one-cycle pulse: out/carry_out/overflow valid.
- out  output  WIDTH  result; holds until the next completion.
- carry_out  output  1  add: unsigned carry out. sub: borrow (1 iff a<b unsigned).
- overflow  output  1  signed overflow. Present only with CHUNKED_ADDSUB_OVERFLOW_EN.

## Operation
- States: IDLE, RUN.
- IDLE → RUN: on an edge where req=1 and busy=0.
  - Latch a, b, op_sub.
  - idx←0.
  - carry←op_sub (two's-complement subtract: a + ~b + 1).
- RUN, each edge:
  - chunk idx = a[idx] + (op_sub ? ~b[idx] : b[idx]) + carry.
  - Write the sum into out[idx*CHUNK_WIDTH +: CHUNK_WIDTH].
  - carry←chunk carry; idx←idx+1.
- RUN → IDLE: on the edge writing chunk NUM_CHUNKS-1.
  - busy←0, ack←1.
  - carry_out ← op_sub ? ~carry_final : carry_final.
- out is updated chunk-by-chunk during RUN and is valid only when ack=1.
  - Partial values are visible while busy=1.
  - Consumers must not sample out while busy=1.
- req while busy=1 is ignored. No queueing, no error flag.
- Operand changes after acceptance have no effect.
- Reset, including mid-operation: state←IDLE, busy=0, ack=0, out=0, carry_out=0, overflow=0, idx=0, carry=0. The in-flight operation is lost.

## Timing
- Accepting cycle T (req=1, busy=0).
- busy=1 in cycles T+1..T+NUM_CHUNKS.
- ack=1 in cycle T+NUM_CHUNKS+1 only. With defaults this is T+5.
- busy=0 in the ack cycle, so req=1 there is accepted: back-to-back throughput is one op per NUM_CHUNKS+1 cycles.
- NUM_CHUNKS=1 is legal: ack at T+2.
- All outputs are registered. The combinational path is one CHUNK_WIDTH adder plus operand mux.

## Configuration
- Macro: CHUNKED_ADDSUB_OVERFLOW_EN.
- Defined:
  - The overflow port and its register exist.
  - Add: overflow = (a_msb==b_msb) && (out_msb!=a_msb).
  - Sub: overflow = (a_msb!=b_msb) && (out_msb!=a_msb).
  - Updated on the completing edge, held with out, reset to 0.
- Undefined: the port and logic are absent. All other behaviour is identical.

## Structure
- Package chunked_addsub_pkg holds:
  - state enum (IDLE, RUN).
  - op encoding constants OP_ADD=0, OP_SUB=1.
- Sub-module chunk_adder: combinational CHUNK_WIDTH adder.
  - Inputs: a, b, cin, invert_b.
  - Outputs: sum, cout.
  - Instantiated once and time-multiplexed by idx.

## Test plan
- Add across a chunk boundary:
  - Stimulus: a=0x0000_00FF, b=0x0000_0001, op_sub=0.
  - Response: ack at T+5, out=0x0000_0100, carry_out=0, overflow=0.
- Borrow:
  - Stimulus: a=0, b=1, op_sub=1.
  - Response: out=0xFFFF_FFFF, carry_out=1, overflow=0.
- Signed overflow (with macro):
  - 0x7FFF_FFFF+1 → out=0x8000_0000, overflow=1, carry_out=0.
  - 0x8000_0000-1 → out=0x7FFF_FFFF, overflow=1.
- Back-to-back:
  - Stimulus: req held high; operand pairs (5,3,add) then (5,3,sub).
  - Response: ack cycles 5 apart, out=8 then 2.
  - req pulses while busy=1 produce no extra ack.
- Reset mid-operation:
  - Stimulus: rst low at T+2.
  - Response: immediately busy=0, out=0, ack=0.
  - After release, no ack until a new req. A new op completes correctly.
- Parametrisation:
  - WIDTH=64, CHUNK_WIDTH=16.
  - Stimulus: a=0xFFFF_FFFF_FFFF_FFFF, b=1, op_sub=0.
  - Response: out=0, carry_out=1, ack at T+5.
  - WIDTH=32, CHUNK_WIDTH=32: ack at T+2.
